// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: the start-of-load marker byte and the
// loader FSM state encoding.
package program_loader_pkg;

    // Marker byte that opens a load stream while the loader is idle.
    localparam logic [7:0] StartByte = 8'hA5;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCount = 3'd1,
        StData  = 3'd2,
        StWrite = 3'd3,
        StCheck = 3'd4
    } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Program loader bus: byte-stream handshake plus the instruction-memory write port.
//   byteIn/byteValid/byteReady   incoming load stream (accepted when valid & ready)
//   writeEnable/Address/Data     one-cycle instruction-memory write
// Modport slave is the loader's view; master is the stream source / memory side.
interface program_loader_if #(
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned PC_WIDTH          = 8
);
    logic [7:0]                   byteIn;
    logic                         byteValid;
    logic                         byteReady;
    logic                         writeEnable;
    logic [PC_WIDTH-1:0]          writeAddress;
    logic [INSTRUCTION_WIDTH-1:0] writeData;

    modport slave (
        input  byteIn,
        input  byteValid,
        output byteReady,
        output writeEnable,
        output writeAddress,
        output writeData
    );

    modport master (
        output byteIn,
        output byteValid,
        input  byteReady,
        input  writeEnable,
        input  writeAddress,
        input  writeData
    );
endinterface

// File: rtl/loader_word_assembler.sv
// Assembles payload bytes MSB-first into instruction words and keeps the running XOR
// checksum of every payload byte of the current load.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         start of a new load: reset byte counter and checksum
//   shift_i         accepted payload byte on byte_i
//   word_o          word being assembled (complete once the last byte has shifted in)
//   checksum_o      XOR of all payload bytes shifted since clear_i
//   last_o          next shifted byte completes a word
module loader_word_assembler #(
    parameter int unsigned INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         shift_i,
    input  logic [7:0]                   byte_i,
    output logic [INSTRUCTION_WIDTH-1:0] word_o,
    output logic [7:0]                   checksum_o,
    output logic                         last_o
);
    localparam int unsigned BytesPerWord = INSTRUCTION_WIDTH / 8;
    localparam logic [2:0]  LastByte     = 3'(BytesPerWord - 1);

    logic [INSTRUCTION_WIDTH-1:0] word_q, word_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic [7:0]                   cks_q, cks_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        cks_d  = cks_q;
        if (clear_i) begin
            cnt_d = '0;
            cks_d = '0;
        end else if (shift_i) begin
            word_d = (word_q << 8) | INSTRUCTION_WIDTH'(byte_i);
            cks_d  = cks_q ^ byte_i;
            cnt_d  = (cnt_q == LastByte) ? 3'd0 : cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= '0;
            cks_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            cks_q  <= cks_d;
        end
    end

    assign word_o     = word_q;
    assign checksum_o = cks_q;
    assign last_o     = (cnt_q == LastByte);

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a byte stream (A5, count N, N words MSB-first, XOR checksum),
// writes each word to instruction memory and holds the CPU in reset while loading.
//   clock      rising-edge clock
//   isResetN   asynchronous active-low reset
//   bus        stream handshake and instruction-memory write port (slave side)
//   cpuHold    high while a load is in progress or after a failed load
//   loadDone   one-cycle pulse after a load whose checksum matched
//   loadError  sticky checksum failure, cleared by the next start byte
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned PC_WIDTH          = 8
) (
    input  logic             clock,
    input  logic             isResetN,
    program_loader_if.slave  bus,
    output logic             cpuHold,
    output logic             loadDone,
    output logic             loadError
);
    state_e                       state_q, state_d;
    logic [7:0]                   count_q, count_d;   // words still to write
    logic [PC_WIDTH-1:0]          addr_q, addr_d;
    logic                         hold_q, hold_d;
    logic                         done_q, done_d;
    logic                         error_q, error_d;

    logic                         byte_ready;
    logic                         accept;
    logic                         asm_clear;
    logic                         asm_shift;
    logic                         asm_last;
    logic [INSTRUCTION_WIDTH-1:0] asm_word;
    logic [7:0]                   asm_checksum;

    assign byte_ready = (state_q != StWrite);
    assign accept     = bus.byteValid & byte_ready;

    loader_word_assembler #(
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
    ) u_assembler (
        .clk_i      (clock),
        .rst_ni     (isResetN),
        .clear_i    (asm_clear),
        .shift_i    (asm_shift),
        .byte_i     (bus.byteIn),
        .word_o     (asm_word),
        .checksum_o (asm_checksum),
        .last_o     (asm_last)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        error_d   = error_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Non-start bytes are silently dropped here.
                if (accept && bus.byteIn == StartByte) begin
                    state_d = StCount;
                    hold_d  = 1'b1;
                    error_d = 1'b0;
                end
            end
            StCount: begin
                if (accept) begin
                    if (bus.byteIn == 8'd0) begin
                        state_d = StIdle;
                        hold_d  = 1'b0;
                    end else begin
                        state_d   = StData;
                        count_d   = bus.byteIn;
                        addr_d    = '0;
                        asm_clear = 1'b1;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_last) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 8'd1;
                state_d = (count_q == 8'd1) ? StCheck : StData;
            end
            StCheck: begin
                if (accept) begin
                    state_d = StIdle;
                    if (bus.byteIn == asm_checksum) begin
                        hold_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        // CPU stays held until a later load succeeds.
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            state_q <= StIdle;
            count_q <= '0;
            addr_q  <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign bus.byteReady    = byte_ready;
    assign bus.writeEnable  = (state_q == StWrite);
    assign bus.writeAddress = addr_q;
    assign bus.writeData    = asm_word;
    assign cpuHold          = hold_q;
    assign loadDone         = done_q;
    assign loadError        = error_q;

endmodule
